// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED output controller with static, blink and PWM-dimming modes.
// Optional register readback is built only when LED_READBACK_EN is defined.
module led_pwm_ctrl #(
  parameter int LED_W    = 24,
  parameter int DATA_W   = 16,
  parameter int PWM_BITS = 8,
  parameter int PRESC_W  = 16
) (
  input  logic              led_clk,
  input  logic              ledrst,
  input  logic              ledcs,
  input  logic              ledwrite,
  input  logic [2:0]        ledaddr,
  input  logic [DATA_W-1:0] ledwdata,
  output logic [DATA_W-1:0] ledrdata,
  output logic [LED_W-1:0]  ledout
);

  localparam logic [1:0] ADDR_LO    = 2'd0;
  localparam logic [1:0] ADDR_HI    = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_PRESC = 2'd3;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_PWM    = 2'b10;

  logic [LED_W-1:0]    pattern_reg, pattern_next;
  logic [1:0]          mode_reg, mode_next;
  logic [PWM_BITS-1:0] duty_reg, duty_next;
  logic [PRESC_W-1:0]  presc_reg, presc_next;
  logic [PRESC_W-1:0]  presc_cnt_reg, presc_cnt_next;
  logic                phase_reg, phase_next;
  logic [PWM_BITS-1:0] pwm_cnt_reg, pwm_cnt_next;
  logic [LED_W-1:0]    ledout_reg, ledout_next;

  logic wr_lo, wr_hi, wr_ctrl, wr_presc;
  logic pwm_on;
  logic gate;

  // Byte address bit 0 carries no meaning on this 16-bit register file.
  logic unused_addr_bit;
  assign unused_addr_bit = ledaddr[0];

  always_comb begin
    wr_lo    = 1'b0;
    wr_hi    = 1'b0;
    wr_ctrl  = 1'b0;
    wr_presc = 1'b0;
    if (ledcs && ledwrite) begin
      case (ledaddr[2:1])
        ADDR_LO:    wr_lo    = 1'b1;
        ADDR_HI:    wr_hi    = 1'b1;
        ADDR_CTRL:  wr_ctrl  = 1'b1;
        ADDR_PRESC: wr_presc = 1'b1;
        default:    ;
      endcase
    end
  end

  always_comb begin
    pattern_next = pattern_reg;
    mode_next    = mode_reg;
    duty_next    = duty_reg;
    presc_next   = presc_reg;
    if (wr_lo)
      pattern_next[15:0] = ledwdata;
    if (wr_hi)
      pattern_next[LED_W-1:16] = ledwdata[LED_W-17:0];
    if (wr_ctrl) begin
      mode_next = ledwdata[1:0];
      duty_next = ledwdata[15 -: PWM_BITS];
    end
    if (wr_presc)
      presc_next = PRESC_W'(ledwdata);
  end

  // A PRESC write restarts the blink period in the on-phase.
  always_comb begin
    presc_cnt_next = presc_cnt_reg + PRESC_W'(1);
    phase_next     = phase_reg;
    if (wr_presc || (presc_reg == '0)) begin
      presc_cnt_next = '0;
      phase_next     = 1'b1;
    end else if (presc_cnt_reg == presc_reg - PRESC_W'(1)) begin
      presc_cnt_next = '0;
      phase_next     = ~phase_reg;
    end
  end

  assign pwm_cnt_next = pwm_cnt_reg + PWM_BITS'(1);
  assign pwm_on       = (pwm_cnt_reg < duty_reg);

  always_comb begin
    case (mode_reg)
      MODE_STATIC: gate = 1'b1;
      MODE_BLINK:  gate = phase_reg;
      MODE_PWM:    gate = pwm_on;
      default:     gate = phase_reg & pwm_on;
    endcase
  end

  for (genvar gi = 0; gi < LED_W; gi++) begin : g_led_gate
    assign ledout_next[gi] = pattern_reg[gi] & gate;
  end

  always_ff @(posedge led_clk) begin
    if (ledrst) begin
      pattern_reg   <= '0;
      mode_reg      <= '0;
      duty_reg      <= '0;
      presc_reg     <= '0;
      presc_cnt_reg <= '0;
      phase_reg     <= 1'b1;
      pwm_cnt_reg   <= '0;
      ledout_reg    <= '0;
    end else begin
      pattern_reg   <= pattern_next;
      mode_reg      <= mode_next;
      duty_reg      <= duty_next;
      presc_reg     <= presc_next;
      presc_cnt_reg <= presc_cnt_next;
      phase_reg     <= phase_next;
      pwm_cnt_reg   <= pwm_cnt_next;
      ledout_reg    <= ledout_next;
    end
  end

  assign ledout = ledout_reg;

`ifdef LED_READBACK_EN
  logic [DATA_W-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (!ledrst && ledcs && !ledwrite) begin
      case (ledaddr[2:1])
        ADDR_LO:    rdata = pattern_reg[15:0];
        ADDR_HI:    rdata[LED_W-17:0] = pattern_reg[LED_W-1:16];
        ADDR_CTRL: begin
          rdata[1:0]            = mode_reg;
          rdata[15 -: PWM_BITS] = duty_reg;
        end
        ADDR_PRESC: rdata = DATA_W'(presc_reg);
        default:    ;
      endcase
    end
  end

  assign ledrdata = rdata;
`else
  assign ledrdata = '0;
`endif

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed self-checking bench for led_pwm_ctrl; expectations adapt to LED_READBACK_EN.
module tb_led_pwm_ctrl;

  localparam int LED_W = 24;

`ifdef LED_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic             led_clk;
  logic             ledrst;
  logic             ledcs;
  logic             ledwrite;
  logic [2:0]       ledaddr;
  logic [15:0]      ledwdata;
  logic [15:0]      ledrdata;
  logic [LED_W-1:0] ledout;

  int n_checks;
  int n_fail;

  led_pwm_ctrl #(.LED_W(LED_W), .DATA_W(16), .PWM_BITS(8), .PRESC_W(16)) dut (
    .led_clk  (led_clk),
    .ledrst   (ledrst),
    .ledcs    (ledcs),
    .ledwrite (ledwrite),
    .ledaddr  (ledaddr),
    .ledwdata (ledwdata),
    .ledrdata (ledrdata),
    .ledout   (ledout)
  );

  initial led_clk = 1'b0;
  always #5 led_clk = ~led_clk;

  task automatic tick();
    @(posedge led_clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    ledcs    = 1'b1;
    ledwrite = 1'b1;
    ledaddr  = a;
    ledwdata = d;
    tick();
    ledcs    = 1'b0;
    ledwrite = 1'b0;
    $display("write addr=%0d data=%h ledout=%h", a, d, ledout);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    ledcs    = 1'b1;
    ledwrite = 1'b0;
    ledaddr  = a;
    #1;
    d = ledrdata;
    ledcs = 1'b0;
    $display("read  addr=%0d data=%h", a, d);
  endtask

  task automatic test_reset();
    ledrst = 1'b1;
    repeat (3) tick();
    ledcs = 1'b1; ledwrite = 1'b0; ledaddr = 3'd4; #1;
    n_checks++;
    if (ledrdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_rdata got=%h exp=%h", ledrdata, 16'h0000);
    end
    ledcs = 1'b0;
    ledrst = 1'b0;
    tick();
    n_checks++;
    if (ledout !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_ledout got=%h exp=%h", ledout, 24'h000000);
    end
  endtask

  task automatic test_static();
    bus_write(3'd0, 16'hA5A5);
    bus_write(3'd2, 16'h00C3);
    n_checks++;
    if (ledout !== 24'h00A5A5) begin
      n_fail++;
      $display("FAIL static_latency got=%h exp=%h", ledout, 24'h00A5A5);
    end
    tick();
    n_checks++;
    if (ledout !== 24'hC3A5A5) begin
      n_fail++;
      $display("FAIL static_pattern got=%h exp=%h", ledout, 24'hC3A5A5);
    end
    bus_write(3'd3, 16'hFF12);
    tick();
    n_checks++;
    if (ledout !== 24'h12A5A5) begin
      n_fail++;
      $display("FAIL static_hi_trunc got=%h exp=%h", ledout, 24'h12A5A5);
    end
  endtask

  task automatic test_blink();
    logic [LED_W-1:0] exp;
    bus_write(3'd0, 16'hFFFF);
    bus_write(3'd2, 16'h00FF);
    bus_write(3'd4, 16'h0001);
    bus_write(3'd6, 16'd4);
    for (int j = 1; j <= 6; j++) begin
      tick();
      exp = (((j - 1) / 4) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      n_checks++;
      if (ledout !== exp) begin
        n_fail++;
        $display("FAIL blink4 cyc=%0d got=%h exp=%h", j, ledout, exp);
      end
    end
    bus_write(3'd6, 16'd2);
    n_checks++;
    if (ledout !== 24'h000000) begin
      n_fail++;
      $display("FAIL blink_rewrite got=%h exp=%h", ledout, 24'h000000);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      exp = (((j - 1) / 2) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      n_checks++;
      if (ledout !== exp) begin
        n_fail++;
        $display("FAIL blink2 cyc=%0d got=%h exp=%h", j, ledout, exp);
      end
    end
  endtask

  task automatic test_pwm();
    logic [7:0] duty_tab [3];
    int         exp_tab  [3];
    int         on_cnt;
    int         bad_cnt;
    duty_tab[0] = 8'd64;  exp_tab[0] = 64;
    duty_tab[1] = 8'd0;   exp_tab[1] = 0;
    duty_tab[2] = 8'd255; exp_tab[2] = 255;
    bus_write(3'd6, 16'd0);
    for (int t = 0; t < 3; t++) begin
      bus_write(3'd4, {duty_tab[t], 8'h02});
      on_cnt  = 0;
      bad_cnt = 0;
      for (int j = 0; j < 256; j++) begin
        tick();
        if (ledout == 24'hFFFFFF) on_cnt++;
        else if (ledout != 24'h000000) bad_cnt++;
      end
      $display("pwm duty=%0d on=%0d", duty_tab[t], on_cnt);
      n_checks++;
      if (on_cnt !== exp_tab[t]) begin
        n_fail++;
        $display("FAIL pwm_count duty=%0d got=%0d exp=%0d", duty_tab[t], on_cnt, exp_tab[t]);
      end
      n_checks++;
      if (bad_cnt !== 0) begin
        n_fail++;
        $display("FAIL pwm_partial duty=%0d got=%0d exp=0", duty_tab[t], bad_cnt);
      end
    end
  endtask

  task automatic test_blink_pwm();
    int on_cnt;
    bus_write(3'd4, 16'h8003);
    bus_write(3'd6, 16'd512);
    on_cnt = 0;
    for (int j = 0; j < 512; j++) begin
      tick();
      if (ledout == 24'hFFFFFF) on_cnt++;
    end
    $display("blink_pwm on-phase on=%0d", on_cnt);
    n_checks++;
    if (on_cnt !== 256) begin
      n_fail++;
      $display("FAIL blink_pwm_on got=%0d exp=256", on_cnt);
    end
    on_cnt = 0;
    for (int j = 0; j < 512; j++) begin
      tick();
      if (ledout != 24'h000000) on_cnt++;
    end
    $display("blink_pwm off-phase on=%0d", on_cnt);
    n_checks++;
    if (on_cnt !== 0) begin
      n_fail++;
      $display("FAIL blink_pwm_off got=%0d exp=0", on_cnt);
    end
  endtask

  task automatic test_readback();
    logic [15:0] d;
    logic [15:0] exp;
    bus_write(3'd2, 16'hFF12);
    bus_write(3'd0, 16'h5A5A);
    bus_write(3'd5, 16'h8003);
    bus_write(3'd6, 16'h0200);
    bus_read(3'd3, d);
    exp = RB_EN ? 16'h0012 : 16'h0000;
    n_checks++;
    if (d !== exp) begin
      n_fail++;
      $display("FAIL rb_hi got=%h exp=%h", d, exp);
    end
    bus_read(3'd0, d);
    exp = RB_EN ? 16'h5A5A : 16'h0000;
    n_checks++;
    if (d !== exp) begin
      n_fail++;
      $display("FAIL rb_lo got=%h exp=%h", d, exp);
    end
    bus_read(3'd4, d);
    exp = RB_EN ? 16'h8003 : 16'h0000;
    n_checks++;
    if (d !== exp) begin
      n_fail++;
      $display("FAIL rb_ctrl got=%h exp=%h", d, exp);
    end
    bus_read(3'd7, d);
    exp = RB_EN ? 16'h0200 : 16'h0000;
    n_checks++;
    if (d !== exp) begin
      n_fail++;
      $display("FAIL rb_presc got=%h exp=%h", d, exp);
    end
    ledcs = 1'b0; ledwrite = 1'b0; ledaddr = 3'd4; #1;
    n_checks++;
    if (ledrdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL rb_cs_low got=%h exp=%h", ledrdata, 16'h0000);
    end
  endtask

  task automatic test_reset_during_blink();
    logic [15:0] d;
    bus_write(3'd0, 16'hFFFF);
    bus_write(3'd2, 16'h00FF);
    bus_write(3'd4, 16'h0001);
    bus_write(3'd6, 16'd4);
    tick();
    tick();
    ledrst   = 1'b1;
    ledcs    = 1'b1;
    ledwrite = 1'b1;
    ledaddr  = 3'd0;
    ledwdata = 16'h1234;
    tick();
    ledwrite = 1'b0;
    ledaddr  = 3'd4;
    #1;
    $display("reset+write ledout=%h rdata=%h", ledout, ledrdata);
    n_checks++;
    if (ledout !== 24'h000000) begin
      n_fail++;
      $display("FAIL rst_ledout got=%h exp=%h", ledout, 24'h000000);
    end
    n_checks++;
    if (ledrdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_rdata got=%h exp=%h", ledrdata, 16'h0000);
    end
    ledcs  = 1'b0;
    ledrst = 1'b0;
    bus_read(3'd4, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_ctrl_rb got=%h exp=%h", d, 16'h0000);
    end
    tick();
    n_checks++;
    if (ledout !== 24'h000000) begin
      n_fail++;
      $display("FAIL rst_pattern got=%h exp=%h", ledout, 24'h000000);
    end
    bus_write(3'd2, 16'h0001);
    tick();
    n_checks++;
    if (ledout !== 24'h010000) begin
      n_fail++;
      $display("FAIL rst_write_lost got=%h exp=%h", ledout, 24'h010000);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ledrst   = 1'b1;
    ledcs    = 1'b0;
    ledwrite = 1'b0;
    ledaddr  = 3'd0;
    ledwdata = 16'h0000;
    test_reset();
    test_static();
    test_blink();
    test_pwm();
    test_blink_pwm();
    test_readback();
    test_reset_during_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
